// File: rtl/tick_gen_if.sv
// tick_gen_if -- divisor write port for tick_gen.
//
// Groups the runtime divisor write strobe, channel index and value.
//   wr_en  : divisor write strobe
//   wr_ch  : target channel index (3 bits, up to 8 channels)
//   wr_div : new divisor value (WIDTH bits; must match tick_gen WIDTH)
//
// Modports:
//   master : the side that issues writes (drives all signals)
//   slave  : tick_gen (samples all signals)
interface tick_gen_if #(
    parameter int unsigned WIDTH = 26
);
    logic             wr_en;
    logic [2:0]       wr_ch;
    logic [WIDTH-1:0] wr_div;

    modport master (output wr_en, output wr_ch, output wr_div);
    modport slave  (input  wr_en, input  wr_ch, input  wr_div);
endinterface

// File: rtl/tick_gen.sv
// tick_gen -- parametrised multi-channel clock-enable generator.
//
// Each channel divides the advance events by a runtime-programmable divisor
// and produces a one-cycle tick strobe plus a 50 % duty square wave, both
// registered. A divisor of 0 disables the channel (tick low, sq frozen).
//
// Ports:
//   clk   : system clock, rising edge
//   clr_n : asynchronous active-low reset (div=DEF_DIV, cnt/tick/sq=0)
//   en    : global run enable; low freezes all counting
//   sync  : synchronous restart of all channels (cnt/tick/sq cleared)
//   wr    : divisor write port (tick_gen_if.slave: wr_en, wr_ch, wr_div)
//   tick  : per-channel one-cycle strobe
//   sq    : per-channel square wave, toggles with each tick
//
// Build option:
//   TICK_GEN_CASCADE_EN -- when defined, channel i>0 advances only on ticks
//   of channel i-1, so channel periods multiply along the chain. Otherwise
//   every channel advances on en and runs independently.
module tick_gen #(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned WIDTH   = 26,
    parameter int unsigned DEF_DIV = 50000000
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              en,
    input  logic              sync,
    tick_gen_if.slave         wr,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] sq
);

    localparam logic [WIDTH-1:0] DEF_DIV_W = WIDTH'(DEF_DIV);
    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

    logic [WIDTH-1:0]  div_q [NUM_CH];
    logic [WIDTH-1:0]  cnt_q [NUM_CH];
    logic [NUM_CH-1:0] adv;

    always_comb begin
        adv = '0;
`ifdef TICK_GEN_CASCADE_EN
        // Chain uses the registered tick of the previous stage, so stage i
        // fires one cycle after the upstream pulse that completes its count.
        adv[0] = en;
        for (int unsigned i = 1; i < NUM_CH; i++) begin
            adv[i] = en & tick[i-1];
        end
`else
        adv = {NUM_CH{en}};
`endif
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                div_q[i] <= DEF_DIV_W;
                cnt_q[i] <= '0;
            end
            tick <= '0;
            sq   <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                // Writes to indices >= NUM_CH never match any channel.
                if (sync) begin
                    // Sync wins over counting but must not drop a divisor write.
                    if (wr.wr_en && (wr.wr_ch == 3'(i))) begin
                        div_q[i] <= wr.wr_div;
                    end
                    cnt_q[i] <= '0;
                    tick[i]  <= 1'b0;
                    sq[i]    <= 1'b0;
                end else if (wr.wr_en && (wr.wr_ch == 3'(i))) begin
                    div_q[i] <= wr.wr_div;
                    cnt_q[i] <= '0;
                    tick[i]  <= 1'b0;
                end else if (div_q[i] == '0) begin
                    cnt_q[i] <= '0;
                    tick[i]  <= 1'b0;
                end else if (adv[i] && (cnt_q[i] >= div_q[i] - ONE_W)) begin
                    // >= rather than == keeps the counter from ever running
                    // past div-1, whatever state it was left in.
                    cnt_q[i] <= '0;
                    tick[i]  <= 1'b1;
                    sq[i]    <= ~sq[i];
                end else if (adv[i]) begin
                    cnt_q[i] <= cnt_q[i] + ONE_W;
                    tick[i]  <= 1'b0;
                end else begin
                    tick[i]  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen -- self-checking bench for tick_gen (NUM_CH=2, WIDTH=8, DEF_DIV=5).
//
// Default build: a table of per-cycle vectors covering default divisor,
// runtime write, en freeze, sync with simultaneous write, div=1, div=0 and an
// out-of-range write. With TICK_GEN_CASCADE_EN defined the table is replaced
// by a cascade sequence. Both builds check reset and asynchronous mid-run reset.
module tb_tick_gen;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       en;
    logic       sync;
    logic [1:0] tick;
    logic [1:0] sq;

    int checks   = 0;
    int failures = 0;

    tick_gen_if #(.WIDTH(8)) wr_bus ();

    tick_gen #(
        .NUM_CH (2),
        .WIDTH  (8),
        .DEF_DIV(5)
    ) dut (
        .clk  (clk),
        .clr_n(clr_n),
        .en   (en),
        .sync (sync),
        .wr   (wr_bus.slave),
        .tick (tick),
        .sq   (sq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       sync;
        logic       wr_en;
        logic [2:0] wr_ch;
        logic [7:0] wr_div;
        logic [1:0] exp_tick;
        logic [1:0] exp_sq;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, input logic s, input logic w,
                       input logic [2:0] ch, input logic [7:0] dv,
                       input logic [1:0] et, input logic [1:0] es);
        vec_t v;
        v.en = e; v.sync = s; v.wr_en = w; v.wr_ch = ch; v.wr_div = dv;
        v.exp_tick = et; v.exp_sq = es;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic drive_idle();
        en = 1'b0; sync = 1'b0;
        wr_bus.wr_en = 1'b0; wr_bus.wr_ch = '0; wr_bus.wr_div = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        clr_n = 1'b0;
        drive_idle();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_tick", 8'(tick), 8'h0);
        check("reset_sq",   8'(sq),   8'h0);
        @(negedge clk);
        clr_n = 1'b1;

`ifndef TICK_GEN_CASCADE_EN
        // en sync wr ch div  tick  sq      (tick/sq shown as {ch1,ch0})
        for (int i = 0; i < 4; i++) add(1,0,0,0,0, 2'b00, 2'b00);   // rows 1-4
        add(1,0,0,0,0, 2'b11, 2'b11);                               // 5: first tick
        add(1,0,0,0,0, 2'b00, 2'b11);
        add(1,0,0,0,0, 2'b00, 2'b11);
        add(1,0,1,1,3, 2'b00, 2'b11);                               // 8: write ch1 div=3
        add(1,0,0,0,0, 2'b00, 2'b11);
        add(1,0,0,0,0, 2'b01, 2'b10);                               // 10: ch0 unaffected
        add(1,0,0,0,0, 2'b10, 2'b00);                               // 11: ch1 3 after write
        add(1,0,0,0,0, 2'b00, 2'b00);
        add(1,0,0,0,0, 2'b00, 2'b00);
        add(1,0,0,0,0, 2'b10, 2'b10);                               // 14
        add(1,0,0,0,0, 2'b01, 2'b11);                               // 15
        add(1,0,0,0,0, 2'b00, 2'b11);
        add(1,0,0,0,0, 2'b10, 2'b01);                               // 17: ch0 cnt=2
        for (int i = 0; i < 4; i++) add(0,0,0,0,0, 2'b00, 2'b01);   // 18-21: frozen
        add(1,0,0,0,0, 2'b00, 2'b01);
        add(1,0,0,0,0, 2'b00, 2'b01);
        add(1,0,0,0,0, 2'b11, 2'b10);                               // 24: ch0 late by 4
        add(1,1,1,1,5, 2'b00, 2'b00);                               // 25: sync + write ch1
        for (int i = 0; i < 4; i++) add(1,0,0,0,0, 2'b00, 2'b00);
        add(1,0,0,0,0, 2'b11, 2'b11);                               // 30: realigned
        add(1,0,1,0,1, 2'b00, 2'b11);                               // 31: ch0 div=1
        add(1,0,0,0,0, 2'b01, 2'b10);
        add(1,0,0,0,0, 2'b01, 2'b11);
        add(1,0,0,0,0, 2'b01, 2'b10);
        add(1,0,0,0,0, 2'b11, 2'b01);                               // 35
        add(1,0,1,0,0, 2'b00, 2'b01);                               // 36: ch0 div=0
        add(1,0,0,0,0, 2'b00, 2'b01);
        add(1,0,0,0,0, 2'b00, 2'b01);
        add(1,0,1,2,1, 2'b00, 2'b01);                               // 39: wr_ch=2 ignored
        add(1,0,0,0,0, 2'b10, 2'b11);                               // 40

        foreach (vecs[k]) begin
            @(negedge clk);
            en = vecs[k].en; sync = vecs[k].sync;
            wr_bus.wr_en = vecs[k].wr_en; wr_bus.wr_ch = vecs[k].wr_ch;
            wr_bus.wr_div = vecs[k].wr_div;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_tick", k + 1), 8'(tick), 8'(vecs[k].exp_tick));
            check($sformatf("vec%0d_sq",   k + 1), 8'(sq),   8'(vecs[k].exp_sq));
        end
`else
        // Cascade: div[1]=3 then div[0]=4 with en low, then run.
        @(negedge clk);
        wr_bus.wr_en = 1'b1; wr_bus.wr_ch = 3'd1; wr_bus.wr_div = 8'd3;
        @(negedge clk);
        wr_bus.wr_ch = 3'd0; wr_bus.wr_div = 8'd4;
        @(negedge clk);
        wr_bus.wr_en = 1'b0;
        en = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            @(posedge clk);
            #1;
            check($sformatf("casc%0d_tick0", j), 8'(tick[0]), 8'((j % 4) == 0));
            check($sformatf("casc%0d_tick1", j), 8'(tick[1]), 8'((j > 1) && (((j - 1) % 12) == 0)));
        end
`endif

        // Asynchronous reset mid-operation
        @(negedge clk);
        drive_idle();
        en = 1'b1;
        @(posedge clk);
        #2;
        clr_n = 1'b0;
        #1;
        check("async_rst_tick", 8'(tick), 8'h0);
        check("async_rst_sq",   8'(sq),   8'h0);
        @(negedge clk);
        clr_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst%0d_tick0", k), 8'(tick[0]), 8'(k == 5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
